// File: rtl/conv_accumulator.sv
// -----------------------------------------------------------------------------
// conv_accumulator
//
// Reduces the KERNEL_SIZE**2 signed fixed-point products of one convolution
// window to a single output pixel: the sum of all products plus a bias,
// saturated to DATA_WIDTH bits. The product bus is captured in one handshake,
// then LANES products are folded into a wide accumulator per cycle. The
// saturated result is presented on a valid/ready output.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. A producer holds its data stable while
// valid is high and ready is low. This block raises in_ready only in IDLE. It
// holds result/overflow stable while out_valid is high.
//
// Ports
//   clk        in   1                          clock, rising-edge
//   rst_n      in   1                          asynchronous active-low reset
//   in_valid   in   1                          products/bias valid
//   in_ready   out  1                          block can accept a window (IDLE)
//   products   in   KERNEL_SIZE**2*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bias       in   DATA_WIDTH                 signed bias, same Q format
//   out_valid  out  1                          result valid
//   out_ready  in   1                          downstream accepts the result
//   result     out  DATA_WIDTH                 saturated signed sum
//   overflow   out  1                          result was saturated
// -----------------------------------------------------------------------------
module conv_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int LANES       = 5
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] products,
    input  logic [DATA_WIDTH-1:0]                     bias,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_WIDTH-1:0]                     result,
    output logic                                      overflow
);

    // Number of products in one window.
    localparam int NP    = KERNEL_SIZE * KERNEL_SIZE;
    // Accumulate beats per window.
    localparam int NB    = NP / LANES;
    // Wide enough to hold NP products plus the bias without ever wrapping.
    localparam int ACC_W = DATA_WIDTH + $clog2(NP + 1) + 1;
    // Beat counter width; at least one bit even for a single-beat reduction.
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    // Saturation bounds expressed in accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Elaboration-time sanity checks on the parameter set.
    generate
        if ((NP % LANES) != 0) begin : g_bad_lanes
            $error("conv_accumulator: LANES must divide KERNEL_SIZE**2");
        end
        if ((FRAC_BIT < 0) || (FRAC_BIT >= DATA_WIDTH)) begin : g_bad_frac
            $error("conv_accumulator: FRAC_BIT must lie inside DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                    state;
    logic [BW-1:0]             beat;
    logic signed [ACC_W-1:0]   acc;
    logic [NP*DATA_WIDTH-1:0]  prod_buf;

    logic signed [ACC_W-1:0]   beat_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   bias_ext;
    logic [DATA_WIDTH-1:0]     sat_result;
    logic                      sat_overflow;

    // Ready is a pure decode of the state so upstream sees it settle right
    // after reset release and never glitches on data inputs.
    assign in_ready = (state == IDLE);

    assign bias_ext = {{(ACC_W - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};

    // Sum of the LANES products selected by the current beat. Only the
    // captured buffer is read, so whatever sits on the product bus outside
    // a handshake never reaches the accumulator.
    always_comb begin
        logic [DATA_WIDTH-1:0] lane;
        beat_sum = '0;
        lane     = '0;
        for (int l = 0; l < LANES; l++) begin
            lane     = prod_buf[((int'(beat) * LANES) + l) * DATA_WIDTH +: DATA_WIDTH];
            beat_sum = beat_sum + {{(ACC_W - DATA_WIDTH){lane[DATA_WIDTH-1]}}, lane};
        end
        acc_next = acc + beat_sum;
    end

    // Clamp the final full-precision sum into DATA_WIDTH.
    always_comb begin
        sat_result   = acc_next[DATA_WIDTH-1:0];
        sat_overflow = 1'b0;
        if (acc_next > SAT_MAX) begin
            sat_result   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
            sat_overflow = 1'b1;
        end else if (acc_next < SAT_MIN) begin
            sat_result   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
            sat_overflow = 1'b1;
        end
    end

    // Control FSM with registered outputs. Reset is asynchronous so an
    // in-flight job is dropped and out_valid falls without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            acc       <= '0;
            prod_buf  <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is implied by IDLE.
                    if (in_valid) begin
                        prod_buf <= products;
                        acc      <= bias_ext;
                        beat     <= '0;
                        state    <= ACCUM;
                    end
                end

                ACCUM: begin
                    acc <= acc_next;
                    if (beat == LAST_BEAT) begin
                        // Final beat: result comes from the sum including
                        // this beat, not from the registered acc.
                        beat      <= '0;
                        result    <= sat_result;
                        overflow  <= sat_overflow;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    beat      <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for conv_accumulator (default parameters).
// Expected pixels come from a plain-integer model: sum all lanes plus bias,
// then clamp to the signed 16-bit range.
// -----------------------------------------------------------------------------
module tb_conv_accumulator;

    localparam int DW = 16;
    localparam int NL = 25;
    localparam int NB = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NL*DW-1:0]  products;
    logic [DW-1:0]     bias;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     result;
    logic              overflow;

    int n_total = 0;
    int n_bad   = 0;

    int cur_lanes[NL];
    int cur_bias;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    conv_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .products  (products),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    // ---------------- reference model ----------------
    task automatic model(output logic [DW-1:0] r, output logic o);
        longint s;
        s = cur_bias;
        for (int i = 0; i < NL; i++) s += cur_lanes[i];
        if (s > 32767) begin
            r = 16'h7FFF; o = 1'b1;
        end else if (s < -32768) begin
            r = 16'h8000; o = 1'b1;
        end else begin
            r = s[15:0]; o = 1'b0;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load_inputs();
        for (int i = 0; i < NL; i++) products[i*DW +: DW] = DW'(cur_lanes[i]);
        bias = DW'(cur_bias);
    endtask

    task automatic set_case1();
        for (int i = 0; i < NL; i++) cur_lanes[i] = 256;
        cur_bias = 0;
    endtask

    task automatic set_case2();
        for (int i = 0; i < NL; i++) cur_lanes[i] = (i % 2 == 0) ? 512 : -512;
        cur_bias = 128;
    endtask

    task automatic set_const(input int v, input int b);
        for (int i = 0; i < NL; i++) cur_lanes[i] = v;
        cur_bias = b;
    endtask

    // Presents cur_lanes/cur_bias, waits for acceptance, then collects the
    // result with out_ready high. lat = edges from accept to out_valid.
    task automatic run_job(output int lat, output logic [DW-1:0] res,
                           output logic ov, output logic one_cycle, output bit ok);
        int w;
        ok = 1'b1; lat = 0; res = '0; ov = 1'b0; one_cycle = 1'b0;
        load_inputs();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0; ok = 1'b0; return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        products = 'x;
        bias     = 'x;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            ok = 1'b0; return;
        end
        res = result;
        ov  = overflow;
        @(posedge clk); #1;
        one_cycle = !out_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        products = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_total++; if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h want 0000", result); end
        n_total++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat; logic [DW-1:0] res; logic ov, one; bit ok;
        set_case1();
        run_job(lat, res, ov, one, ok);
        n_total++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout: got %b want 1", ok); end
        n_total++; if (lat != NB) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, NB); end
        n_total++; if (res !== 16'h1900) begin n_bad++; $display("FAIL basic_result: got %h want 1900", res); end
        n_total++; if (ov !== 1'b0) begin n_bad++; $display("FAIL basic_overflow: got %b want 0", ov); end
        n_total++; if (one !== 1'b1) begin n_bad++; $display("FAIL basic_one_cycle: got %b want 1", one); end
    endtask

    task automatic test_alternating();
        int lat; logic [DW-1:0] res; logic ov, one; bit ok;
        set_case2();
        run_job(lat, res, ov, one, ok);
        n_total++; if (ok !== 1'b1) begin n_bad++; $display("FAIL alt_timeout: got %b want 1", ok); end
        n_total++; if (res !== 16'h0280) begin n_bad++; $display("FAIL alt_result: got %h want 0280", res); end
        n_total++; if (ov !== 1'b0) begin n_bad++; $display("FAIL alt_overflow: got %b want 0", ov); end
    endtask

    task automatic test_saturation();
        int lat; logic [DW-1:0] res; logic ov, one; bit ok;
        set_const(32767, 32767);
        run_job(lat, res, ov, one, ok);
        n_total++; if (ok !== 1'b1) begin n_bad++; $display("FAIL satpos_timeout: got %b want 1", ok); end
        n_total++; if (res !== 16'h7FFF) begin n_bad++; $display("FAIL satpos_result: got %h want 7fff", res); end
        n_total++; if (ov !== 1'b1) begin n_bad++; $display("FAIL satpos_overflow: got %b want 1", ov); end
        set_const(-32768, -32768);
        run_job(lat, res, ov, one, ok);
        n_total++; if (ok !== 1'b1) begin n_bad++; $display("FAIL satneg_timeout: got %b want 1", ok); end
        n_total++; if (res !== 16'h8000) begin n_bad++; $display("FAIL satneg_result: got %h want 8000", res); end
        n_total++; if (ov !== 1'b1) begin n_bad++; $display("FAIL satneg_overflow: got %b want 1", ov); end
    endtask

    task automatic test_stall();
        int lat, w;
        set_case1();
        load_inputs();
        in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid = 1'b0; products = 'x;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_total++; if (lat != NB) begin n_bad++; $display("FAIL stall_latency: got %0d want %0d", lat, NB); end
        // A second request arrives while the output is stalled.
        set_case2();
        load_inputs();
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_total++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid_held c=%0d: got %b want 1", c, out_valid); end
            n_total++; if (result !== 16'h1900) begin n_bad++; $display("FAIL stall_result_held c=%0d: got %h want 1900", c, result); end
            n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;   // output handshake edge
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
        n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_not_early_accept: got %b want 1", in_ready); end
        @(posedge clk); #1;   // accept edge of the second job
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_second_accept: got %b want 0", in_ready); end
        in_valid = 1'b0; products = 'x;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_total++; if (result !== 16'h0280 || lat != NB) begin n_bad++; $display("FAIL stall_second_result: got %h lat %0d want 0280 lat %0d", result, lat, NB); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, seen, w; logic [DW-1:0] res; logic ov, one; bit ok;
        set_case1();
        load_inputs();
        in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;           // accepted, beat 0 next
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end   // now at beat 2
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        n_total++; if (seen != 0) begin n_bad++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
        set_case2();
        run_job(lat, res, ov, one, ok);
        n_total++; if (ok !== 1'b1 || res !== 16'h0280 || lat != NB) begin n_bad++; $display("FAIL midrst_next: got %h lat %0d ok %b want 0280 lat %0d", res, lat, ok, NB); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, nres;
        logic [DW-1:0] res_seen[2];
        acc1 = -1; acc2 = -1; nres = 0;
        res_seen[0] = '0; res_seen[1] = '0;
        set_case1();
        load_inputs();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
            if (out_valid && out_ready) begin
                res_seen[nres] = result; nres++;
            end
            if (in_valid && in_ready) begin
                if (acc1 < 0) acc1 = cyc; else acc2 = cyc;
            end
            @(posedge clk); #1;
            if (acc2 >= 0) begin
                in_valid = 1'b0;
            end else if (acc1 >= 0) begin
                set_case2();
                load_inputs();
            end
        end
        in_valid = 1'b0;
        n_total++; if (nres != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", nres); end
        n_total++; if (acc2 - acc1 != NB + 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", acc2 - acc1, NB + 2); end
        n_total++; if (res_seen[0] !== 16'h1900) begin n_bad++; $display("FAIL b2b_first: got %h want 1900", res_seen[0]); end
        n_total++; if (res_seen[1] !== 16'h0280) begin n_bad++; $display("FAIL b2b_second: got %h want 0280", res_seen[1]); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat, mode; logic [DW-1:0] res, exp_r; logic ov, exp_o, one; bit ok;
        for (int j = 0; j < 40; j++) begin
            mode = $urandom_range(0, 3);
            for (int i = 0; i < NL; i++) begin
                case (mode)
                    0: cur_lanes[i] = int'($urandom_range(0, 600)) - 300;
                    1: cur_lanes[i] = int'($urandom_range(0, 65535)) - 32768;
                    2: cur_lanes[i] = int'($urandom_range(0, 3000));
                    default: cur_lanes[i] = -int'($urandom_range(0, 3000));
                endcase
            end
            cur_bias = int'($urandom_range(0, 65535)) - 32768;
            model(exp_r, exp_o);
            run_job(lat, res, ov, one, ok);
            n_total++;
            if (ok !== 1'b1 || res !== exp_r || ov !== exp_o || lat != NB || one !== 1'b1) begin
                n_bad++;
                $display("FAIL random_%0d: got res %h ov %b lat %0d ok %b want res %h ov %b lat %0d",
                         j, res, ov, lat, ok, exp_r, exp_o, NB);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_alternating();
        test_saturation();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
